// File: rtl/rf_ctrl_pkg.sv
// Shared types and widths for the register-file write path.
// Used by the write-back arbiter and by the register file's decode logic.
package rf_ctrl_pkg;

  localparam int RF_AW = 4;
  localparam int RF_DW = 32;

  typedef enum logic [1:0] {
    FULL = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10,
    LI32 = 2'b11
  } wr_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    LI_HI = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Write-back request channel: one requester (master) presents a write, the arbiter (slave) accepts it.
interface rf_wr_arbiter_if;
  import rf_ctrl_pkg::*;

  logic             valid;
  logic             ready;
  logic [RF_AW-1:0] dst;
  logic [RF_DW-1:0] data;
  wr_mode_t         mode;

  modport master (output valid, dst, data, mode, input ready);
  modport slave  (input valid, dst, data, mode, output ready);

endinterface

// File: rtl/rf_wr_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; a grant is also the accept, so the pointer moves on every grant.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic a_valid_i,
  input  logic b_valid_i,
  output logic a_gnt_o,
  output logic b_gnt_o
);

  // last_b_q = 1 means port B was granted last, so A wins the next tie.
  logic last_b_q, last_b_d;

  // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
  always_comb begin
    a_gnt_o  = en_i && a_valid_i && (!b_valid_i || last_b_q);
    b_gnt_o  = en_i && b_valid_i && (!a_valid_i || !last_b_q);
    last_b_d = last_b_q;
    if (a_gnt_o)      last_b_d = 1'b0;
    else if (b_gnt_o) last_b_d = 1'b1;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_b_q <= 1'b1;
    else        last_b_q <= last_b_d;
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Arbitrates ALU (A) and load-return (B) write-backs onto the register file's single registered write port.
module rf_wr_arbiter
  import rf_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  rf_wr_arbiter_if.slave   a,
  rf_wr_arbiter_if.slave   b,
  output logic             rf_wr,
  output logic [RF_AW-1:0] rf_wr_dst,
  output logic [RF_DW-1:0] rf_wr_data,
  output logic             rf_high,
  output logic             rf_low,
  output logic             busy
);

  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_LI_HI = LI_HI;

  logic [0:0]       state_q, state_d;
  logic             wr_q, wr_d;
  logic [RF_AW-1:0] dst_q, dst_d;
  logic [RF_DW-1:0] data_q, data_d;
  logic             high_q, high_d;
  logic             low_q, low_d;
  logic             li_q, li_d;
  logic [15:0]      li_hi_q, li_hi_d;

  logic             a_gnt, b_gnt;
  logic [RF_AW-1:0] sel_dst;
  logic [RF_DW-1:0] sel_data;
  wr_mode_t         sel_mode;

  // Gating with rst_n keeps both readys low for the whole reset pulse.
  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (rst_n && (state_q == S_IDLE)),
    .a_valid_i (a.valid),
    .b_valid_i (b.valid),
    .a_gnt_o   (a_gnt),
    .b_gnt_o   (b_gnt)
  );

  assign a.ready  = a_gnt;
  assign b.ready  = b_gnt;
  assign sel_dst  = a_gnt ? a.dst  : b.dst;
  assign sel_data = a_gnt ? a.data : b.data;
  assign sel_mode = a_gnt ? a.mode : b.mode;

  always_comb begin
    state_d = S_IDLE;
    wr_d    = 1'b0;
    dst_d   = dst_q;
    data_d  = data_q;
    high_d  = 1'b0;
    low_d   = 1'b0;
    li_d    = 1'b0;
    li_hi_d = li_hi_q;
    if (state_q == S_LI_HI) begin
      wr_d   = 1'b1;
      data_d = {16'b0, li_hi_q};
      high_d = 1'b1;
      li_d   = 1'b1;
    end else if (a_gnt || b_gnt) begin
      wr_d  = 1'b1;
      dst_d = sel_dst;
      unique case (sel_mode)
        FULL: data_d = sel_data;
        HIGH: begin
          data_d = {16'b0, sel_data[15:0]};
          high_d = 1'b1;
        end
        LOW: begin
          data_d = {16'b0, sel_data[15:0]};
          low_d  = 1'b1;
        end
        LI32: begin
          // Phase 1 is a plain full write of the low half; the high half is merged next cycle.
          data_d  = {16'b0, sel_data[15:0]};
          li_d    = 1'b1;
          li_hi_d = sel_data[31:16];
          state_d = S_LI_HI;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      dst_q   <= '0;
      data_q  <= '0;
      high_q  <= 1'b0;
      low_q   <= 1'b0;
      li_q    <= 1'b0;
      li_hi_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      high_q  <= high_d;
      low_q   <= low_d;
      li_q    <= li_d;
      li_hi_q <= li_hi_d;
    end
  end

  assign rf_wr      = wr_q;
  assign rf_wr_dst  = dst_q;
  assign rf_wr_data = data_q;
  assign rf_high    = high_q;
  assign rf_low     = low_q;
  // li_q marks either LI32 phase on the outputs, so busy spans both output cycles.
  assign busy       = (state_q == S_LI_HI) || li_q;

endmodule
